// File: rtl/traffic_sink_pkg.sv
// Shared types for the traffic-generator link and the sink that terminates it.
//  FLIT_TYPE_t  : flit kind carried in the head word
//  FLIT_t       : one link word (head control/address + body data)
//  SINK_STATE_t : receive FSM states of traffic_sink
//  SINK_ERR_t   : error codes reported on o_err_code
package traffic_sink_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    NONE_FLIT = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic              valid;
    FLIT_TYPE_t        ftype;
    logic [ADDR_W-1:0] xaddr;
    logic [ADDR_W-1:0] yaddr;
  } FLIT_HEAD_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } FLIT_BODY_t;

  typedef struct packed {
    FLIT_HEAD_t head;
    FLIT_BODY_t body;
  } FLIT_t;

  typedef enum logic [2:0] {
    SK_IDLE      = 3'd0,
    SK_GRANT     = 3'd1,
    SK_WAIT_HEAD = 3'd2,
    SK_BODY      = 3'd3,
    SK_WAIT_TAIL = 3'd4,
    SK_DRAIN     = 3'd5
  } SINK_STATE_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_NO_HEAD  = 3'd1,
    ERR_DUP_HEAD = 3'd2,
    ERR_SHORT    = 3'd3,
    ERR_LONG     = 3'd4,
    ERR_BAD_TYPE = 3'd5,
    ERR_TIMEOUT  = 3'd6
  } SINK_ERR_t;

endpackage

// File: rtl/traffic_sink_if.sv
// Traffic-generator link: transmit request, grant, and the flit word.
//  i_transmit : sender has a packet buffered (level, held until granted)
//  o_send     : one-cycle grant from the sink
//  i_flit     : flit word; valid only when i_flit.head.valid=1
// master = sender side, slave = sink side.
interface traffic_sink_if;
  import traffic_sink_pkg::*;

  logic  i_transmit;
  logic  o_send;
  FLIT_t i_flit;

  modport master (output i_transmit, output i_flit, input o_send);
  modport slave  (input i_transmit, input i_flit, output o_send);

endinterface

// File: rtl/traffic_sink.sv
// Receiving end of the traffic-generator link. Grants one pending packet at a
// time, consumes HEAD / BODY x BODY_COUNT / TAIL, checks ordering and body count,
// and reports packet statistics and errors.
// Optional feature: define TRAFFIC_SINK_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive flit-less cycles (ERR_TIMEOUT); otherwise waits forever.
// Ports:
//  clk, reset_n  clock, asynchronous active-low reset
//  i_enable      sink may issue grants
//  lnk           link interface (slave): i_transmit, o_send, i_flit
//  o_busy        FSM not in IDLE
//  o_pkt_done    one-cycle pulse after a good TAIL
//  o_pkt_count   good packets received (wraps)
//  o_last_xaddr  / o_last_yaddr  head address of last good packet
//  o_checksum    XOR of body data of last good packet
//  o_err         one-cycle pulse per detected error
//  o_err_code    code of most recent error (held)
//  o_err_count   errors detected (wraps)
module traffic_sink
  import traffic_sink_pkg::*;
#(
  parameter int unsigned BODY_COUNT     = 1,
  parameter int unsigned PKT_CNT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_enable,
  traffic_sink_if.slave        lnk,
  output logic                 o_busy,
  output logic                 o_pkt_done,
  output logic [PKT_CNT_W-1:0] o_pkt_count,
  output logic [ADDR_W-1:0]    o_last_xaddr,
  output logic [ADDR_W-1:0]    o_last_yaddr,
  output logic [DATA_W-1:0]    o_checksum,
  output logic                 o_err,
  output logic [2:0]           o_err_code,
  output logic [PKT_CNT_W-1:0] o_err_count
);

  localparam int unsigned CNT_W = $clog2(BODY_COUNT) + 1;

  localparam logic [2:0] ST_IDLE      = SK_IDLE;
  localparam logic [2:0] ST_GRANT     = SK_GRANT;
  localparam logic [2:0] ST_WAIT_HEAD = SK_WAIT_HEAD;
  localparam logic [2:0] ST_BODY      = SK_BODY;
  localparam logic [2:0] ST_WAIT_TAIL = SK_WAIT_TAIL;
  localparam logic [2:0] ST_DRAIN     = SK_DRAIN;

  // Parameter sanity: a packet needs at least one body, a timeout at least one cycle.
  if (BODY_COUNT == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("traffic_sink: BODY_COUNT and TIMEOUT_CYCLES must be >= 1");
  end

  logic [2:0]        state, state_d;
  FLIT_t             flit;
  logic              fvalid;
  FLIT_TYPE_t        ftype;
  logic              head_acc_c, body_acc_c, pkt_good_c, err_c, timeout_c;
  SINK_ERR_t         err_code_c;
  logic [CNT_W-1:0]  body_cnt;
  logic [DATA_W-1:0] run_cks;
  logic [ADDR_W-1:0] sh_xaddr, sh_yaddr;

  assign flit   = lnk.i_flit;
  assign fvalid = flit.head.valid;
  assign ftype  = flit.head.ftype;

`ifdef TRAFFIC_SINK_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              rx_c;
  logic [IDLE_W-1:0] idle_cnt;

  assign rx_c      = (state == ST_WAIT_HEAD) || (state == ST_BODY) ||
                     (state == ST_WAIT_TAIL) || (state == ST_DRAIN);
  // Fires on the TIMEOUT_CYCLES-th consecutive flit-less receive cycle.
  assign timeout_c = rx_c && !fvalid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared outside receive states (covers grant) and on any flit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             idle_cnt <= '0;
    else if (!rx_c || fvalid) idle_cnt <= '0;
    else if (!timeout_c)      idle_cnt <= idle_cnt + IDLE_W'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Next state and per-flit decisions
  always_comb begin
    state_d    = state;
    head_acc_c = 1'b0;
    body_acc_c = 1'b0;
    pkt_good_c = 1'b0;
    err_c      = 1'b0;
    err_code_c = ERR_NONE;
    case (state)
      ST_IDLE: if (i_enable && lnk.i_transmit) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_WAIT_HEAD;
      ST_WAIT_HEAD: if (fvalid) begin
        case (ftype)
          HEAD_FLIT: begin head_acc_c = 1'b1; state_d = ST_BODY; end
          BODY_FLIT: begin err_c = 1'b1; err_code_c = ERR_NO_HEAD; state_d = ST_DRAIN; end
          TAIL_FLIT: begin err_c = 1'b1; err_code_c = ERR_NO_HEAD; state_d = ST_IDLE; end
          default:   begin err_c = 1'b1; err_code_c = ERR_BAD_TYPE; state_d = ST_DRAIN; end
        endcase
      end
      ST_BODY: if (fvalid) begin
        case (ftype)
          HEAD_FLIT: begin err_c = 1'b1; err_code_c = ERR_DUP_HEAD; state_d = ST_DRAIN; end
          BODY_FLIT: begin
            body_acc_c = 1'b1;
            if (body_cnt == CNT_W'(BODY_COUNT - 1)) state_d = ST_WAIT_TAIL;
          end
          TAIL_FLIT: begin err_c = 1'b1; err_code_c = ERR_SHORT; state_d = ST_IDLE; end
          default:   begin err_c = 1'b1; err_code_c = ERR_BAD_TYPE; state_d = ST_DRAIN; end
        endcase
      end
      ST_WAIT_TAIL: if (fvalid) begin
        case (ftype)
          HEAD_FLIT: begin err_c = 1'b1; err_code_c = ERR_DUP_HEAD; state_d = ST_DRAIN; end
          BODY_FLIT: begin err_c = 1'b1; err_code_c = ERR_LONG; state_d = ST_DRAIN; end
          TAIL_FLIT: begin pkt_good_c = 1'b1; state_d = ST_IDLE; end
          default:   begin err_c = 1'b1; err_code_c = ERR_BAD_TYPE; state_d = ST_DRAIN; end
        endcase
      end
      // Silently discard until the packet boundary.
      ST_DRAIN: if (fvalid && ftype == TAIL_FLIT) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Timeout only fires on flit-less cycles, so it never collides with a flit decision.
    if (timeout_c) begin
      state_d    = ST_IDLE;
      err_c      = 1'b1;
      err_code_c = ERR_TIMEOUT;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lnk.o_send   <= 1'b0;
      o_busy       <= 1'b0;
      o_pkt_done   <= 1'b0;
      o_pkt_count  <= '0;
      o_last_xaddr <= '0;
      o_last_yaddr <= '0;
      o_checksum   <= '0;
      o_err        <= 1'b0;
      o_err_code   <= '0;
      o_err_count  <= '0;
      body_cnt     <= '0;
      run_cks      <= '0;
      sh_xaddr     <= '0;
      sh_yaddr     <= '0;
    end else begin
      lnk.o_send <= (state_d == ST_GRANT);
      o_busy     <= (state_d != ST_IDLE);
      o_pkt_done <= pkt_good_c;
      o_err      <= err_c;
      if (head_acc_c) begin
        sh_xaddr <= flit.head.xaddr;
        sh_yaddr <= flit.head.yaddr;
        run_cks  <= '0;
        body_cnt <= '0;
      end
      if (body_acc_c) begin
        run_cks  <= run_cks ^ flit.body.data;
        body_cnt <= body_cnt + CNT_W'(1);
      end
      if (pkt_good_c) begin
        o_pkt_count  <= o_pkt_count + PKT_CNT_W'(1);
        o_last_xaddr <= sh_xaddr;
        o_last_yaddr <= sh_yaddr;
        o_checksum   <= run_cks;
      end
      if (err_c) begin
        o_err_code  <= err_code_c;
        o_err_count <= o_err_count + PKT_CNT_W'(1);
      end
    end
  end

endmodule
